// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory stage: data priority
// with a bounded D-streak cap. Optional grant timeout enabled by `define MEM_ARB_TIMEOUT_EN.
module memory_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              timeout
);

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       d_req;
  logic       ram_done;
  logic       age_expired;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  logic [AGE_W-1:0] age_q;
  logic             timeout_q;
  logic             grant_stall;

  // A grant is only "stalled" while its requester still holds the request.
  assign grant_stall = ((state_q == DGRANT) && d_req) || ((state_q == IGRANT) && iREN);
  assign age_expired = grant_stall && !ram_done && (age_q == AGE_W'(TIMEOUT - 1));

  // Every grant is entered from IDLE, so clearing in IDLE restarts the age per grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      age_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      age_q     <= (state_q == IDLE) ? '0 : age_q + 1'b1;
      timeout_q <= timeout_q | age_expired;
    end
  end

  assign timeout = timeout_q;
`else
  assign age_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;

    unique case (state_q)
      IDLE: begin
        if (d_req && !(iREN && (streak_q == STREAK_MAX))) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ram_done) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_d = IDLE;
            // Count consecutive D wins only while fetch is actually waiting.
            if (iREN) begin
              streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            end else begin
              streak_d = '0;
            end
          end else if (age_expired) begin
            state_d = IDLE;
          end
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ram_done) begin
            iwait    = 1'b0;
            iload    = ramload;
            state_d  = IDLE;
            streak_d = '0;
          end else if (age_expired) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter; the RAM is modelled with a fixed BUSY latency
// (auto mode) or a directly driven ramstate (manual mode), read data = address ^ A5A50000.
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ram_auto;
  logic [1:0] ram_manual;
  int         ram_lat;
  int         busy_cnt = 0;
  logic       ram_en;

  always #5 CLK = ~CLK;

  memory_arbiter #(.WORD_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  assign ram_en  = ramREN | ramWEN;
  assign ramload = ramaddr ^ 32'hA5A5_0000;

  always_comb begin
    if (!ram_auto)              ramstate = ram_manual;
    else if (!ram_en)           ramstate = FREE;
    else if (busy_cnt >= ram_lat) ramstate = ACCESS;
    else                        ramstate = BUSY;
  end

  always @(posedge CLK) begin
    if (ram_auto && ram_en && (ramstate != ACCESS)) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_auto = 1'b1; ram_manual = FREE; ram_lat = 0;
    step(); step();
    iREN = 1'b1; dREN = 1'b1;
    step();
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL reset_ramREN got=%b exp=0", ramREN); end
    n_cmp++; if (ramWEN !== 1'b0) begin n_bad++; $display("FAIL reset_ramWEN got=%b exp=0", ramWEN); end
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL reset_iwait got=%b exp=1", iwait); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL reset_dwait got=%b exp=1", dwait); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    step();
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0;
    step();
  endtask

  task automatic test_contention();
    ram_auto = 1'b1; ram_lat = 2;
    daddr = 32'h100; iaddr = 32'h200;
    dREN = 1'b1; iREN = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge CLK);
      case (cyc)
        1: begin
          n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL cont_bubble_ramREN got=%b exp=0", ramREN); end
        end
        2: begin
          n_cmp++; if (ramaddr !== 32'h100) begin n_bad++; $display("FAIL cont_d_addr got=%h exp=00000100", ramaddr); end
          n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL cont_d_ramREN got=%b exp=1", ramREN); end
          n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL cont_i_stalled got=%b exp=1", iwait); end
        end
        3: begin
          n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL cont_dwait_busy got=%b exp=1", dwait); end
        end
        4: begin
          n_cmp++; if (dwait !== 1'b0) begin n_bad++; $display("FAIL cont_dwait_done got=%b exp=0", dwait); end
          n_cmp++; if (dload !== 32'hA5A5_0100) begin n_bad++; $display("FAIL cont_dload got=%h exp=a5a50100", dload); end
          n_cmp++; if (iload !== 32'h0) begin n_bad++; $display("FAIL cont_iload_zero got=%h exp=0", iload); end
        end
        6: begin
          n_cmp++; if (ramaddr !== 32'h200) begin n_bad++; $display("FAIL cont_i_addr got=%h exp=00000200", ramaddr); end
        end
        8: begin
          n_cmp++; if (iwait !== 1'b0) begin n_bad++; $display("FAIL cont_iwait_done got=%b exp=0", iwait); end
          n_cmp++; if (iload !== 32'hA5A5_0200) begin n_bad++; $display("FAIL cont_iload got=%h exp=a5a50200", iload); end
        end
        default: ;
      endcase
      step();
      if (cyc == 4) dREN = 1'b0;
      if (cyc == 8) iREN = 1'b0;
    end
    $display("contention: D then I served");
  endtask

  task automatic test_starvation();
    logic [9:0] exp_is_i;
    int         k;
    exp_is_i = 10'b10_0001_0000;
    k = 0;
    ram_auto = 1'b1; ram_lat = 0;
    daddr = 32'h300; iaddr = 32'h400;
    dREN = 1'b1; iREN = 1'b1;
    for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
      @(negedge CLK);
      if (!dwait || !iwait) begin
        n_cmp++;
        if ((!iwait) !== exp_is_i[k] || (!iwait && !dwait)) begin
          n_bad++;
          $display("FAIL starve_order idx=%0d got_i=%b got_d=%b exp_i=%b", k, !iwait, !dwait, exp_is_i[k]);
        end
        k++;
      end
      step();
    end
    n_cmp++;
    if (k != 10) begin n_bad++; $display("FAIL starve_budget completions got=%0d exp=10", k); end
    dREN = 1'b0; iREN = 1'b0;
    step();
    $display("starvation: %0d completions observed", k);
  endtask

  task automatic test_write_precedence();
    ram_auto = 1'b1; ram_lat = 1;
    iREN = 1'b0; daddr = 32'h40; dstore = 32'hDEADBEEF;
    dREN = 1'b1; dWEN = 1'b1;
    @(negedge CLK);
    step();
    @(negedge CLK);
    n_cmp++; if (ramWEN !== 1'b1) begin n_bad++; $display("FAIL wr_ramWEN got=%b exp=1", ramWEN); end
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL wr_ramREN got=%b exp=0", ramREN); end
    n_cmp++; if (ramstore !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_ramstore got=%h exp=deadbeef", ramstore); end
    step();
    @(negedge CLK);
    n_cmp++; if (dwait !== 1'b0) begin n_bad++; $display("FAIL wr_dwait got=%b exp=0", dwait); end
    n_cmp++; if (dload !== 32'h0) begin n_bad++; $display("FAIL wr_dload got=%h exp=0", dload); end
    n_cmp++; if (ramaddr !== 32'h40) begin n_bad++; $display("FAIL wr_ramaddr got=%h exp=00000040", ramaddr); end
    step();
    dREN = 1'b0; dWEN = 1'b0; dstore = '0;
    step();
    $display("write_precedence: write of deadbeef completed");
  endtask

  task automatic test_withdrawal();
    ram_auto = 1'b0; ram_manual = BUSY;
    daddr = 32'h500; iaddr = 32'h600;
    dREN = 1'b1; iREN = 1'b1;
    @(negedge CLK);
    step();
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL wd_granted_ramREN got=%b exp=1", ramREN); end
    step();
    dREN = 1'b0;
    @(negedge CLK);
    n_cmp++; if ((ramREN | ramWEN) !== 1'b0) begin n_bad++; $display("FAIL wd_enables got=%b%b exp=00", ramREN, ramWEN); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL wd_dwait got=%b exp=1", dwait); end
    step();
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL wd_idle_ramREN got=%b exp=0", ramREN); end
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL wd_idle_iwait got=%b exp=1", iwait); end
    step();
    ram_manual = ACCESS;
    @(negedge CLK);
    n_cmp++; if (ramaddr !== 32'h600) begin n_bad++; $display("FAIL wd_i_addr got=%h exp=00000600", ramaddr); end
    n_cmp++; if (iwait !== 1'b0) begin n_bad++; $display("FAIL wd_iwait got=%b exp=0", iwait); end
    n_cmp++; if (iload !== 32'hA5A5_0600) begin n_bad++; $display("FAIL wd_iload got=%h exp=a5a50600", iload); end
    step();
    iREN = 1'b0; ram_manual = FREE;
    step();
    $display("withdrawal: D dropped, I granted next");
  endtask

  task automatic test_timeout();
    ram_auto = 1'b0; ram_manual = BUSY;
    iaddr = 32'h700; dREN = 1'b0; iREN = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge CLK);
`ifdef MEM_ARB_TIMEOUT_EN
      if (cyc == 9) begin
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b exp=0", timeout); end
        n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL to_grant_held got=%b exp=1", ramREN); end
      end
      if (cyc == 10) begin
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag got=%b exp=1", timeout); end
        n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL to_abort_ramREN got=%b exp=0", ramREN); end
        n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL to_iwait got=%b exp=1", iwait); end
      end
      if (cyc == 11) begin
        n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL to_rearb got=%b exp=1", ramREN); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b exp=1", timeout); end
      end
`else
      if (cyc == 11) begin
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_tied got=%b exp=0", timeout); end
        n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL to_grant_held got=%b exp=1", ramREN); end
        n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL to_iwait got=%b exp=1", iwait); end
      end
`endif
      step();
    end
    ram_manual = ACCESS;
    @(negedge CLK);
    n_cmp++; if (iwait !== 1'b0) begin n_bad++; $display("FAIL to_complete got=%b exp=0", iwait); end
    step();
    iREN = 1'b0; ram_manual = FREE;
    step();
    $display("timeout: long BUSY grant handled, timeout=%b", timeout);
  endtask

  task automatic test_reset_mid_grant();
    ram_auto = 1'b0; ram_manual = BUSY;
    daddr = 32'h800; dREN = 1'b1;
    @(negedge CLK);
    step();
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ramREN got=%b exp=1", ramREN); end
    step();
    RST = 1'b1;
    step();
    RST = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    n_cmp++; if ((ramREN | ramWEN) !== 1'b0) begin n_bad++; $display("FAIL rst_mid_enables got=%b%b exp=00", ramREN, ramWEN); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL rst_mid_dwait got=%b exp=1", dwait); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_mid_timeout got=%b exp=0", timeout); end
    step();
    ram_manual = FREE;
    $display("reset_mid_grant: in-flight access dropped");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_starvation();
    test_write_precedence();
    test_withdrawal();
    test_timeout();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
